// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and writeback.
// Runs one load or store per instruction on a req/ready data-memory port,
// builds byte enables and lane-replicated store data, and aligns and extends
// load data. The core is held through the stall output while an access is
// outstanding.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   addr           byte address from the execute ALU
//   store_data     store operand (r_out2)
//   mem_read       load requested
//   mem_write      store requested (wins if both are set)
//   addr_mode      [1:0] 00 byte / 01 half / 10 word, [2] zero-extend loads
//   read_data      registered, aligned and extended load result
//   stall          core must hold state this cycle
//   misaligned     one-cycle pulse on a rejected misaligned access
//   bus_error      one-cycle pulse when memory never answers
//   mem_req        request to data memory
//   mem_we         write strobe, valid with mem_req
//   mem_addr       word-aligned address
//   mem_wdata      lane-replicated store data
//   mem_be         byte enables
//   mem_ready      memory accepts/completes the current request
//   mem_rdata      full read word, valid with mem_ready
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            addr_mode,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [1:0]            r_off;
  logic [2:0]            r_mode;
  logic                  r_is_load;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  logic                  r_misaligned;
  logic                  r_bus_error;

  logic                  w_active;
  logic                  w_mis;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic                  w_timeout;

  assign w_active  = mem_read | mem_write;
  assign w_timeout = (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_mis = 1'b0;
    case (addr_mode[1:0])
      2'b01:   w_mis = addr[0];
      2'b10:   w_mis = (addr[1:0] != 2'b00);
      2'b11:   w_mis = 1'b1;
      default: w_mis = 1'b0;
    endcase
  end

  // Store lanes; loads always fetch the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    if (mem_write) begin
      case (addr_mode[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = store_data;
        end
      endcase
    end
  end

  // Load alignment uses the offset and mode captured when the request started.
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_mode[1:0])
      2'b00:   w_load = {{24{~r_mode[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_mode[2] & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active && !w_mis) begin
          stall       = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ready || w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_off        <= '0;
      r_mode       <= '0;
      r_is_load    <= 1'b0;
      r_read_data  <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_active) begin
            if (w_mis) begin
              r_misaligned <= 1'b1;
              r_read_data  <= '0;
            end else begin
              r_addr    <= {addr[DATA_WIDTH-1:2], 2'b00};
              r_we      <= mem_write;
              r_is_load <= ~mem_write;
              r_be      <= w_be;
              r_wdata   <= w_wdata;
              r_off     <= addr[1:0];
              r_mode    <= addr_mode;
              r_cnt     <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (r_is_load) begin
              r_read_data <= w_load;
            end
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_read_data <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = (r_state == REQ);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_be     = r_be;
  assign read_data  = r_read_data;
  assign misaligned = r_misaligned;
  assign bus_error  = r_bus_error;

endmodule
